// File: rtl/rx_queue_pkg.sv
// rtl/rx_queue_pkg.sv - shared UART receive-queue types and sizing
package rx_queue_pkg;
   typedef logic [7:0] byte_t;
   localparam int RXQ_WIDTH    = 8;
   localparam int RXQ_DEPTH    = 16;
   localparam int RXQ_AF_LEVEL = 12;
endpackage

// File: rtl/rx_queue_if.sv
// rtl/rx_queue_if.sv - producer/consumer handshake bundle for the receive queue
interface rx_queue_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             i_enq;
   logic [WIDTH-1:0] i_data;
   logic             i_deq;
   logic             i_clr_overflow;
   logic [WIDTH-1:0] o_data;
   logic             o_empty;
   logic             o_full;
   logic             o_almost_full;
   logic [CW-1:0]    o_count;
   logic             o_overflow;

   modport slave (
      input  i_enq, i_data, i_deq, i_clr_overflow,
      output o_data, o_empty, o_full, o_almost_full, o_count, o_overflow
   );

   modport master (
      output i_enq, i_data, i_deq, i_clr_overflow,
      input  o_data, o_empty, o_full, o_almost_full, o_count, o_overflow
   );
endinterface

// File: rtl/rx_queue.sv
// rtl/rx_queue.sv - show-ahead byte FIFO between the UART receiver and its consumer
// Flags decode the count register directly so they never lag a pointer update.
module rx_queue
   import rx_queue_pkg::*;
#(
   parameter int WIDTH    = RXQ_WIDTH,
   parameter int DEPTH    = RXQ_DEPTH,
   parameter int AF_LEVEL = RXQ_AF_LEVEL
) (
   input logic         i_clk,
   input logic         i_rst,
   rx_queue_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             empty, full, wa, ra, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   // A pop in the same cycle frees the slot, so a full queue still accepts the write.
   assign wa    = bus.i_enq & (~full | bus.i_deq);
   assign ra    = bus.i_deq & ~empty;
   assign drop  = bus.i_enq & full & ~bus.i_deq;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      if (wa) wr_ptr_d = wr_ptr_q + PW'(1);
      if (ra) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wa) - CW'(ra);
      if (drop)                    overflow_d = 1'b1;
      else if (bus.i_clr_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left uncleared by reset.
   always_ff @(posedge i_clk) begin
      if (wa && !i_rst) mem_q[wr_ptr_q] <= bus.i_data;
   end

   assign bus.o_data        = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.o_empty       = empty;
   assign bus.o_full        = full;
   assign bus.o_almost_full = (count_q >= CW'(AF_LEVEL));
   assign bus.o_count       = count_q;
   assign bus.o_overflow    = overflow_q;
endmodule
